// File: rtl/fpmul_result_queue.sv
// FP32 product capture FIFO (first-word-fall-through, 1-cycle latency, no bypass); in_ready drops at DEPTH.
// Sticky exception flags always built; saturating counters only with FPMUL_RESQ_STATS_EN.
module fpmul_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_product,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_product,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sticky_ovf,
  output logic                     sticky_unf,
  input  logic                     clear_sticky,
  output logic [CNT_W-1:0]         ovf_count,
  output logic [CNT_W-1:0]         unf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] product;
    logic        zero;
    logic        ovf;
    logic        unf;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Handshake qualifiers come from the level register only, never from in_valid/out_ready.
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Sign bit is ignored so that -0 is classified as zero as well.
  assign wr_entry = {in_product, (in_product[30:0] == 31'd0), in_overflow, in_underflow};
  assign head     = mem[rd_ptr];

  assign out_product = out_valid ? head.product : 32'd0;
  assign out_flags   = out_valid ? {head.zero, head.ovf, head.unf} : 3'b000;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A flagged push in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      if (push && in_overflow)  sticky_ovf <= 1'b1;
      else if (clear_sticky)    sticky_ovf <= 1'b0;
      if (push && in_underflow) sticky_unf <= 1'b1;
      else if (clear_sticky)    sticky_unf <= 1'b0;
    end
  end

`ifdef FPMUL_RESQ_STATS_EN
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    if (clr)                     return inc ? CNT_W'(1) : '0;
    else if (inc && cnt != '1)   return cnt + CNT_W'(1);
    else                         return cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else begin
      ovf_count <= cnt_next(ovf_count, push & in_overflow, clear_sticky);
      unf_count <= cnt_next(unf_count, push & in_underflow, clear_sticky);
    end
  end
`else
  assign ovf_count = '0;
  assign unf_count = '0;
`endif

endmodule

// File: tb/tb_fpmul_result_queue.sv
// Scoreboard bench for fpmul_result_queue: model pushes expectations at the clock edge,
// a negedge monitor compares the presented head and pops on each handshake.
module tb_fpmul_result_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_product;
  logic             in_overflow;
  logic             in_underflow;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_product;
  logic [2:0]       out_flags;
  logic [2:0]       level;
  logic             sticky_ovf;
  logic             sticky_unf;
  logic             clear_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic [CNT_W-1:0] unf_count;

  fpmul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_flags(out_flags), .level(level),
    .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .clear_sticky(clear_sticky),
    .ovf_count(ovf_count), .unf_count(unf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic [2:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  int   mlevel = 0;
  bit   m_push, m_pop;
  bit   m_sovf = 0, m_sunf = 0;
  int   m_covf = 0, m_cunf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_next(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc && c < CMAX) return c + 1;
    return c;
  endfunction

  // Reference model: acceptance decided from the bench's own occupancy count.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mlevel = 0;
      m_sovf = 0; m_sunf = 0; m_covf = 0; m_cunf = 0;
    end else begin
      m_push = in_valid && (mlevel < DEPTH);
      m_pop  = out_ready && (mlevel > 0);
      if (m_push)
        exp_q.push_back('{p: in_product,
                          f: {(in_product[30:0] == 31'd0), in_overflow, in_underflow}});
      mlevel = mlevel + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      m_covf = sat_next(m_covf, m_push && in_overflow, clear_sticky);
      m_cunf = sat_next(m_cunf, m_push && in_underflow, clear_sticky);
      if (m_push && in_overflow)  m_sovf = 1; else if (clear_sticky) m_sovf = 0;
      if (m_push && in_underflow) m_sunf = 1; else if (clear_sticky) m_sunf = 0;
    end
  end

  // Monitor: compares whatever the DUT presents; pops the scoreboard on a handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_level", 32'(level), 32'(mlevel));
      check("mon_in_ready", 32'(in_ready), 32'(mlevel < DEPTH));
      check("mon_out_valid", 32'(out_valid), 32'(mlevel > 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          check("mon_product", out_product, exp_q[0].p);
          check("mon_flags", 32'(out_flags), 32'(exp_q[0].f));
          if (out_ready && !rst) void'(exp_q.pop_front());
        end
      end else begin
        check("mon_idle_product", out_product, 32'd0);
        check("mon_idle_flags", 32'(out_flags), 32'd0);
      end
      check("mon_sticky_ovf", 32'(sticky_ovf), 32'(m_sovf));
      check("mon_sticky_unf", 32'(sticky_unf), 32'(m_sunf));
`ifdef FPMUL_RESQ_STATS_EN
      check("mon_ovf_count", 32'(ovf_count), 32'(m_covf));
      check("mon_unf_count", 32'(unf_count), 32'(m_cunf));
`else
      check("mon_ovf_count", 32'(ovf_count), 32'd0);
      check("mon_unf_count", 32'(unf_count), 32'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] p, input bit o, input bit u);
    in_valid = v; in_product = p; in_overflow = o; in_underflow = u;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; clear_sticky = 1'b0;
    drive(0, 32'd0, 0, 0);
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_product", out_product, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
    check("rst_counts", 32'({ovf_count, unf_count}), 32'd0);
    mon_en = 1;

    // First push appears one cycle later.
    drive(1, 32'h4000_0000, 0, 0); step();
    drive(0, 32'd0, 0, 0);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_product", out_product, 32'h4000_0000);
    check("lat_flags", 32'(out_flags), 32'd0);
    check("lat_level", 32'(level), 32'd1);

    // Fill to full with -0, a non-zero denormal and an overflowed infinity.
    drive(1, 32'h8000_0000, 0, 0); step();
    drive(1, 32'h0000_0001, 0, 0); step();
    drive(1, 32'h7f80_0000, 1, 0); step();
    drive(0, 32'd0, 0, 0);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_sticky_ovf", 32'(sticky_ovf), 32'd1);

    // Push while full with a pop: push is refused, level drops.
    drive(1, 32'h1111_1111, 0, 0); out_ready = 1'b1; step();
    drive(0, 32'd0, 0, 0); out_ready = 1'b0;
    check("full_pop_level", 32'(level), 32'd3);
    check("negzero_product", out_product, 32'h8000_0000);
    check("negzero_flags", 32'(out_flags), 32'b100);

    out_ready = 1'b1; repeat (3) step(); out_ready = 1'b0;
    check("drained_level", 32'(level), 32'd0);

    clear_sticky = 1'b1; step(); clear_sticky = 1'b0;
    check("clear_sticky_ovf", 32'(sticky_ovf), 32'd0);

    // Streaming: pointers wrap several times, level stays at 1, head is the newest.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h0000_0100 + 32'(i), 0, 0); step();
      check("stream_level", 32'(level), 32'd1);
      check("stream_product", out_product, 32'h0000_0100 + 32'(i));
    end
    drive(0, 32'd0, 0, 0); step(); out_ready = 1'b0;
    check("stream_end_level", 32'(level), 32'd0);

    // Set wins over clear in the same cycle.
    drive(1, 32'h7f80_0000, 1, 0); clear_sticky = 1'b1; step();
    drive(0, 32'd0, 0, 0); clear_sticky = 1'b0;
    check("setwins_sticky_ovf", 32'(sticky_ovf), 32'd1);
`ifdef FPMUL_RESQ_STATS_EN
    check("setwins_ovf_count", 32'(ovf_count), 32'd1);
`else
    check("setwins_ovf_count", 32'(ovf_count), 32'd0);
`endif

    // Four more overflow (+underflow) zero results: ovf total 5, unf total 4, both saturate.
    out_ready = 1'b1;
    drive(1, 32'h0000_0000, 1, 1); repeat (4) step();
    drive(0, 32'd0, 0, 0); repeat (2) step(); out_ready = 1'b0;
    check("sat_sticky_unf", 32'(sticky_unf), 32'd1);
`ifdef FPMUL_RESQ_STATS_EN
    check("sat_ovf_count", 32'(ovf_count), 32'd3);
    check("sat_unf_count", 32'(unf_count), 32'd3);
`else
    check("sat_ovf_count", 32'(ovf_count), 32'd0);
    check("sat_unf_count", 32'(unf_count), 32'd0);
`endif
    clear_sticky = 1'b1; step(); clear_sticky = 1'b0;
    check("clr_counts", 32'({ovf_count, unf_count}), 32'd0);
    check("clr_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);

    // Reset mid-operation discards entries and the concurrent push/pop.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'haaaa_0000 + 32'(i), 0, 0); step();
    end
    check("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1; out_ready = 1'b1; drive(1, 32'h1234_5678, 1, 1); step();
    rst = 1'b0; out_ready = 1'b0; drive(0, 32'd0, 0, 0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_product", out_product, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
    repeat (3) step();

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpmul_result_queue.md
# fpmul_result_queue

Downstream capture stage for the single-cycle FP32 multiplier: registers each accepted product with its overflow/underflow flags into a small FIFO and presents it on a valid/ready interface to the consumer. It also classifies results (zero/overflow/underflow), keeps sticky exception flags, and optionally keeps saturating exception counters. It decouples the multiplier's one-result-per-cycle output from a consumer that may stall.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the exception counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  the multiplier result on in_* is valid this cycle.
- in_ready  out  1  the queue can accept; `in_ready = (level != DEPTH)`.
- in_product  in  32  FP32 product from the multiplier.
- in_overflow  in  1  multiplier overflow flag.
- in_underflow  in  1  multiplier underflow flag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_product  out  32  head product; 0 when out_valid=0.
- out_flags  out  3  {zero, overflow, underflow} of the head entry; 0 when out_valid=0.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- sticky_ovf  out  1  an overflow result has been accepted since the last clear.
- sticky_unf  out  1  an underflow result has been accepted since the last clear.
- clear_sticky  in  1  one-cycle pulse; clears the sticky flags and the counters.
- ovf_count  out  CNT_W  accepted overflow results (saturating).
- unf_count  out  CNT_W  accepted underflow results (saturating).

## Operation
- Push occurs when `in_valid & in_ready`. The stored entry is {in_product, zero, in_overflow, in_underflow}, where `zero = (in_product[30:0] == 0)`. Sign is ignored, so -0 also counts as zero.
- Pop occurs when `out_valid & out_ready`. The read pointer advances.
- The FIFO is first-word-fall-through: out_* reflects the entry at the read pointer directly, with no extra register stage.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is held as an explicit counter.
- Level update rules:
  - Push and pop in the same cycle: level is unchanged.
  - Push only: level +1.
  - Pop only: level −1.
- When full, in_ready=0, even if a pop happens in the same cycle. There is no full-bypass path.
- When empty, out_valid=0 and a push is not forwarded combinationally. There is no empty-bypass path.
- Sticky flags:
  - A flag sets on an accepted push that carries the corresponding flag.
  - clear_sticky clears it.
  - If set and clear occur in the same cycle, set wins.
- in_overflow and in_underflow are both recorded as given, including the case where both are 1. No priority or filtering is applied.
- Memory contents are not reset. Only pointers, level and status state are reset.

## Timing
- Reset values: in_ready=1, out_valid=0, out_product=0, out_flags=0, level=0, sticky_ovf=0, sticky_unf=0, ovf_count=0, unf_count=0.
- Latency: a product pushed at edge N is visible on out_* with out_valid=1 after edge N (one cycle), if the queue was empty.
- Throughput: one push and one pop per cycle, sustained, whenever 0 < level < DEPTH.
- in_ready and out_valid are functions of registered state only. They have no combinational path from in_valid or out_ready.
- If rst is asserted mid-operation, all queued entries are discarded at that edge. Any push or pop presented in that cycle is ignored.
- Sticky flags and counters update at the same edge as the accepting push.

## Configuration
- FPMUL_RESQ_STATS_EN defined:
  - ovf_count and unf_count increment by 1 on each accepted push with the matching flag.
  - They saturate at all-ones.
  - clear_sticky zeroes them; if clear and increment occur in the same cycle, the result is 1.
- Not defined: ovf_count and unf_count are tied to 0 and no counter registers are built. Sticky flags are unaffected.

## Test plan
- Reset, then push 0x40000000 with flags 0 → next cycle out_valid=1, out_product=0x40000000, out_flags=3'b000, level=1.
- Push 0x80000000 (−0) with out_ready=0 → out_flags=3'b100. Then fill to DEPTH=4 → in_ready=0, level=4. A push attempted while full with out_ready=1 → not accepted; level goes to 3.
- Continuous push and pop for 20 cycles with incrementing products → outputs in order with no gaps, level constant. Pointers wrap correctly past entry 3.
- Push with in_overflow=1 while clear_sticky=1 in the same cycle → sticky_ovf=1. With the stats macro, ovf_count=1.
- Stats build: set CNT_W=2 and push 5 overflow results → ovf_count=3 (saturated). Pulse clear_sticky → ovf_count=0, sticky_ovf=0.
- Fill 3 entries, assert rst for one cycle while pushing → level=0, out_valid=0, out_product=0, in_ready=1.
